// File: rtl/melody_sequencer.sv
// melody_sequencer: plays 4-byte ROM note records as a square wave; define MELODY_LOOP_EN to repeat the melody forever.
module melody_sequencer #(
  parameter int CLOCK_HZ      = 25_000_000,
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start_i,
  input  logic                     Stop_i,
  output logic                     ReadEnable_o,
  output logic [ADDRESS_WIDTH-1:0] Address_o,
  input  logic [7:0]               Data_i,
  output logic                     Tone_o,
  output logic                     Busy_o,
  output logic                     Done_o
);
  localparam int US_CYC = CLOCK_HZ / 1_000_000;
  localparam int PW = US_CYC > 1 ? $clog2(US_CYC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(US_CYC - 1);
  typedef enum logic [1:0] {IDLE, FETCH, PLAY, FIN} state_t;
  state_t state_q, state_d;
  logic cap_q, cap_d;
  logic [1:0] idx_q, idx_d;
  logic [ADDRESS_WIDTH-1:0] base_q, base_d, addr_q, addr_d;
  logic [3:0][7:0] rec_q, rec_d;
  logic [15:0] dur_q, dur_d, hcnt_q, hcnt_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [9:0] ms_q, ms_d;
  logic tone_q, tone_d, done_q, done_d;
  logic us_tick, ms_tick;
  logic [15:0] half;
  assign half = {rec_q[2], rec_q[3]};
  assign us_tick = state_q == PLAY && pre_q == PRE_LAST;
  assign ms_tick = us_tick && ms_q == 10'd999;
  always_comb begin
    state_d = state_q;
    cap_d = cap_q;
    idx_d = idx_q;
    base_d = base_q;
    addr_d = addr_q;
    rec_d = rec_q;
    dur_d = dur_q;
    hcnt_d = hcnt_q;
    pre_d = pre_q;
    ms_d = ms_q;
    tone_d = 1'b0;
    done_d = 1'b0;
    case (state_q)
      IDLE: if (Start_i) begin
        state_d = FETCH;
        base_d = '0;
        addr_d = '0;
        idx_d = 2'd0;
        cap_d = 1'b0;
      end
      FETCH: if (!cap_q) cap_d = 1'b1;
      else begin
        rec_d[idx_q] = Data_i;
        cap_d = 1'b0;
        if (idx_q == 2'd1 && {rec_q[0], Data_i} == 16'd0) begin
          done_d = 1'b1;
`ifdef MELODY_LOOP_EN
          base_d = '0;
          addr_d = '0;
          idx_d = 2'd0;
`else
          state_d = FIN;
`endif
        end else if (idx_q == 2'd3) begin
          state_d = PLAY;
          base_d = base_q + ADDRESS_WIDTH'(4);
          dur_d = {rec_q[0], rec_q[1]};
          pre_d = '0;
          ms_d = '0;
          hcnt_d = '0;
        end else begin
          idx_d = idx_q + 2'd1;
          addr_d = base_q + ADDRESS_WIDTH'(idx_q + 2'd1);
        end
      end
      PLAY: begin
        pre_d = us_tick ? '0 : pre_q + 1'b1;
        ms_d = ms_tick ? 10'd0 : ms_q + {9'd0, us_tick};
        dur_d = ms_tick ? dur_q - 16'd1 : dur_q;
        tone_d = tone_q;
        if (us_tick && half != 16'd0) begin
          hcnt_d = hcnt_q == half - 16'd1 ? 16'd0 : hcnt_q + 16'd1;
          tone_d = hcnt_q == half - 16'd1 ? ~tone_q : tone_q;
        end
        if (ms_tick && dur_q == 16'd1) begin
          state_d = FETCH;
          idx_d = 2'd0;
          cap_d = 1'b0;
          addr_d = base_q;
          tone_d = 1'b0;
        end
      end
      FIN: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (Stop_i) begin
      state_d = IDLE;
      cap_d = 1'b0;
      addr_d = addr_q;
      tone_d = 1'b0;
      done_d = 1'b0;
    end
  end
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      cap_q <= 1'b0;
      idx_q <= 2'd0;
      base_q <= '0;
      addr_q <= '0;
      rec_q <= '0;
      dur_q <= '0;
      hcnt_q <= '0;
      pre_q <= '0;
      ms_q <= '0;
      tone_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q <= cap_d;
      idx_q <= idx_d;
      base_q <= base_d;
      addr_q <= addr_d;
      rec_q <= rec_d;
      dur_q <= dur_d;
      hcnt_q <= hcnt_d;
      pre_q <= pre_d;
      ms_q <= ms_d;
      tone_q <= tone_d;
      done_q <= done_d;
    end
  end
  assign ReadEnable_o = state_q == FETCH && !cap_q;
  assign Address_o = addr_q;
  assign Tone_o = tone_q;
  assign Busy_o = state_q != IDLE;
  assign Done_o = done_q;
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed and random melodies checked cycle by cycle against a trace built from the ROM contents.
module tb_melody_sequencer;
  localparam int HZ = 2_000_000;
  localparam int AW = 4;
  localparam int N = 1 << AW;
  localparam int P = HZ / 1_000_000;
  localparam int LOOP_LEN = 12000;
  logic Clock = 1'b0, Reset = 1'b0, Start_i = 1'b0, Stop_i = 1'b0;
  logic ReadEnable_o, Tone_o, Busy_o, Done_o;
  logic [AW-1:0] Address_o;
  logic [7:0] Data_i;
  logic [7:0] rom [N];
  int total = 0, bad = 0;
  int exp_q[$];
  melody_sequencer #(.CLOCK_HZ(HZ), .ADDRESS_WIDTH(AW)) dut (
    .Clock(Clock), .Reset(Reset), .Start_i(Start_i), .Stop_i(Stop_i),
    .ReadEnable_o(ReadEnable_o), .Address_o(Address_o), .Data_i(Data_i),
    .Tone_o(Tone_o), .Busy_o(Busy_o), .Done_o(Done_o)
  );
  always #5 Clock = ~Clock;
  always @(posedge Clock) if (ReadEnable_o) Data_i <= rom[Address_o];
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  function automatic int pk(input bit re, input int addr, input bit tone, input bit busy, input bit done);
    return (int'(re) << (AW + 3)) | ((addr % N) << 3) | (int'(tone) << 2) | (int'(busy) << 1) | int'(done);
  endfunction
  function automatic logic [31:0] outs();
    return 32'({ReadEnable_o, Address_o, Tone_o, Busy_o, Done_o});
  endfunction
  // Expected per-cycle outputs from the cycle after Start_i is accepted.
  function automatic void build(input int limit);
    int base, addr, dur, half;
    bit done, fin;
    base = 0;
    addr = 0;
    done = 1'b0;
    exp_q.delete();
    forever begin
      fin = 1'b0;
      for (int i = 0; i < 4 && !fin; i++) begin
        addr = base + i;
        exp_q.push_back(pk(1'b1, addr, 1'b0, 1'b1, done));
        done = 1'b0;
        exp_q.push_back(pk(1'b0, addr, 1'b0, 1'b1, 1'b0));
        if (i == 1) fin = rom[base] == 8'd0 && rom[base + 1] == 8'd0;
      end
      if (fin) begin
`ifdef MELODY_LOOP_EN
        base = 0;
        done = 1'b1;
`else
        exp_q.push_back(pk(1'b0, addr, 1'b0, 1'b1, 1'b1));
        break;
`endif
      end else begin
        dur = int'(rom[base]) * 256 + int'(rom[base + 1]);
        half = int'(rom[base + 2]) * 256 + int'(rom[base + 3]);
        for (int c = 0; c < P * 1000 * dur; c++)
          exp_q.push_back(pk(1'b0, addr, half != 0 && (c / (P * half)) % 2 == 1, 1'b1, 1'b0));
        base = (base + 4) % N;
      end
      if (exp_q.size() >= limit) break;
    end
    repeat (4) exp_q.push_back(pk(1'b0, addr, 1'b0, 1'b0, 1'b0));
  endfunction
  task automatic do_reset();
    Reset = 1'b0;
    Start_i = 1'b0;
    Stop_i = 1'b0;
    repeat (2) @(negedge Clock);
    check("reset", outs(), 0);
    Reset = 1'b1;
  endtask
  task automatic run(input int stop_at, input int start_at, output int edges, output int dones);
    int bad0, a;
    bit prev;
    bad0 = bad;
    edges = 0;
    dones = 0;
`ifdef MELODY_LOOP_EN
    if (stop_at < 0) stop_at = LOOP_LEN - 1;
`endif
    if (stop_at >= 0) begin
      a = (exp_q[stop_at] >> 3) % N;
      while (exp_q.size() > stop_at + 1) void'(exp_q.pop_back());
      repeat (4) exp_q.push_back(pk(1'b0, a, 1'b0, 1'b0, 1'b0));
    end
    @(negedge Clock) Start_i = 1'b1;
    @(negedge Clock) Start_i = 1'b0;
    prev = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) @(negedge Clock);
      check($sformatf("cyc%0d", i), outs(), exp_q[i]);
      edges += int'(Tone_o != prev);
      prev = Tone_o;
      dones += int'(Done_o);
      Stop_i = i == stop_at;
      Start_i = i == start_at;
      if (bad != bad0) break;
    end
    Stop_i = 1'b0;
    Start_i = 1'b0;
  endtask
  task automatic load(input int k, input int dur, input int half);
    rom[4 * k] = 8'(dur >> 8);
    rom[4 * k + 1] = 8'(dur);
    rom[4 * k + 2] = 8'(half >> 8);
    rom[4 * k + 3] = 8'(half);
  endtask
  initial begin
    int e, d, n, busy_len, stop_at, half, a;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clock);
      check($sformatf("rst_hold%0d", i), outs(), 0);
      Start_i = i[0];
    end
    Start_i = 1'b0;
    do_reset();
    foreach (rom[i]) rom[i] = 8'd0;
    load(0, 5, 100);
    build(LOOP_LEN);
    run(-1, -1, e, d);
`ifndef MELODY_LOOP_EN
    check("tone_edges", e, 50);
    check("done_pulses", d, 1);
`endif
    do_reset();
    load(0, 2, 0);
    build(LOOP_LEN);
    run(-1, -1, e, d);
`ifndef MELODY_LOOP_EN
    check("silent_edges", e, 0);
    check("silent_done", d, 1);
`endif
    do_reset();
    for (int k = 0; k < 4; k++) load(k, 1, 500);
    build(4 * 2008 + 40);
    run(4 * 2008 + 5, -1, e, d);
    check("wrap_done", d, 0);
    do_reset();
    foreach (rom[i]) rom[i] = 8'd0;
    load(0, 8, 500);
    build(LOOP_LEN);
    run(8 + 3001, -1, e, d);
    check("stop_done", d, 0);
    a = (exp_q[exp_q.size() - 1] >> 3) % N;
    @(negedge Clock);
    Start_i = 1'b1;
    Stop_i = 1'b1;
    @(negedge Clock);
    Start_i = 1'b0;
    Stop_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("start_stop%0d", i), outs(), pk(1'b0, a, 1'b0, 1'b0, 1'b0));
      @(negedge Clock);
    end
    load(0, 3, 50);
    @(negedge Clock) Start_i = 1'b1;
    @(negedge Clock) Start_i = 1'b0;
    repeat (1000) @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    check("mid_reset", outs(), 0);
    Reset = 1'b1;
    for (int r = 0; r < 5; r++) begin
      do_reset();
      foreach (rom[i]) rom[i] = 8'($urandom);
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++) begin
        case ($urandom_range(0, 3))
          0: half = 0;
          1: half = $urandom_range(1, 5);
          default: half = $urandom_range(1, 600);
        endcase
        load(k, $urandom_range(1, 2), half);
      end
      rom[4 * n] = 8'd0;
      rom[4 * n + 1] = 8'd0;
      build(LOOP_LEN);
      busy_len = exp_q.size() - 4;
`ifdef MELODY_LOOP_EN
      busy_len = LOOP_LEN - 1;
`endif
      stop_at = $urandom_range(0, 2) == 0 ? $urandom_range(0, busy_len - 1) : -1;
      run(stop_at, $urandom_range(0, busy_len - 1), e, d);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
